controlador_alu: RTL and testbench
==================================

# controlador_alu

Sequential driver and collector for the combinational ALU. Accepts one operation command at a time over a valid/ready handshake and registers the operands and selection onto the ALU inputs. After a fixed settling delay it captures the ALU result and flags, then returns them to the consumer over a second valid/ready handshake. It sits between the user command source (switch/button front end or test sequencer) and the ALU, which the parent instantiates.

## Interface
- ancho, 3: operand MSB index; data width is ancho+1.
- ESPERA, 1: cycles the ALU inputs are held stable before capture; legal range 1..15.
- ANCHO_CONT, 8: width of the completed-operation counter.

- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valido  input  1  command present.
- cmd_listo  output  1  block can accept a command.
- cmd_operandoA  input  ancho+1  operand A.
- cmd_operandoB  input  ancho+1  operand B.
- cmd_seleccion  input  4  operation code.
- cmd_acumular  input  1  when 1, use the accumulator in place of cmd_operandoA.
- operandoA, operandoB  output  ancho+1  registered ALU operands.
- seleccion  output  4  registered ALU operation code.
- resultado  input  ancho+1  ALU result.
- banderas  input  4  ALU flags.
- rsp_valido  output  1  response present.
- rsp_listo  input  1  consumer accepts the response.
- rsp_resultado  output  ancho+1  captured result.
- rsp_banderas  output  4  captured flags, passed through unmodified.
- rsp_error  output  1  command rejected.
- ops_completadas  output  ANCHO_CONT  count of successful responses.

## Operation
- Operation codes:
  - 0 suma, 1 resta, 2 multiplicacion, 3 division, 4 modulo
  - 5 AND, 6 OR, 7 XOR, 8 shift left, 9 shift right
  - 10–15 are illegal.
- States are INACTIVO, EJECUTAR, RESPONDER.
- INACTIVO:
  - cmd_listo=1.
  - On cmd_valido, the command is validated.
  - Illegal code, or code 3/4 with an effective operandoB of 0, means error. The block loads rsp_resultado=0, rsp_banderas=0, rsp_error=1 and goes to RESPONDER. The ALU ports are left unchanged.
  - Otherwise it loads operandoA (cmd_operandoA, or the accumulator when cmd_acumular=1), operandoB and seleccion. It clears the wait counter and goes to EJECUTAR.
- EJECUTAR:
  - cmd_listo=0 and the ALU ports are held.
  - The wait counter increments each cycle.
  - In the ESPERA-th EJECUTAR cycle, the block captures resultado→rsp_resultado and banderas→rsp_banderas, sets rsp_error=0, and goes to RESPONDER.
- RESPONDER:
  - rsp_valido=1 and all rsp_* outputs are stable.
  - On rsp_listo the block goes to INACTIVO.
  - If rsp_error=0, the accumulator takes rsp_resultado and ops_completadas increments, wrapping modulo 2^ANCHO_CONT.
- The accumulator is an internal register, ancho+1 bits, reset 0. It is updated only by successful responses.
- cmd_valido outside INACTIVO is ignored; nothing is queued.
- ALU port registers keep their last value between operations.

## Timing
- Reset (rst_n=0, asynchronous) takes effect immediately:
  - state INACTIVO, cmd_listo=1, rsp_valido=0
  - operandoA=operandoB=seleccion=0
  - rsp_resultado=0, rsp_banderas=0, rsp_error=0
  - accumulator=0, ops_completadas=0
- Reset mid-operation discards the pending command and response.
- Accept edge t0 (cmd_valido & cmd_listo):
  - ALU ports are updated in cycle t0+1.
  - rsp_valido goes high in cycle t0+ESPERA+1.
  - Error commands give rsp_valido in cycle t0+1.
- Response handshake edge t1 (rsp_valido & rsp_listo): cmd_listo=1 in cycle t1+1.
- Minimum throughput is one operation per ESPERA+2 cycles.
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- rsp_listo held high before rsp_valido is legal; the response completes in its first valid cycle.

## Structure
- Package alu_pkg holds:
  - enum of the 10 operation codes
  - constant SELECCION_MAX=9
  - state enum (INACTIVO, EJECUTAR, RESPONDER)
- Single module, no sub-module. The ALU stays outside and is wired by the parent.

## Test plan
All scenarios use ancho=3 and ESPERA=1.
- Suma: A=5, B=3, sel=0, accepted at t0 → ALU ports 5/3/0 in t0+1; rsp_valido in t0+2; rsp_resultado=8, rsp_error=0; ops_completadas=1.
- Division by zero: A=7, B=0, sel=3 → rsp_valido in t0+1; rsp_resultado=0, rsp_error=1; ALU ports unchanged; counter unchanged.
- Illegal code: sel=12 → rsp_error=1, rsp_banderas=0; accumulator unchanged.
- Accumulate:
  - Suma 6+2 → 8.
  - Then cmd_acumular=1, B=3, sel=1 → operandoA=8 on the ALU; result 5.
- Backpressure: rsp_listo low for 5 cycles → rsp_* stable and cmd_listo=0; a second cmd_valido pulse is ignored; completion follows when rsp_listo rises.
- Reset in EJECUTAR: rst_n pulse → all outputs 0 and cmd_listo=1 immediately; accumulator=0; the next command executes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// ---- alu_pkg: operation codes, FSM states and command check for controlador_alu ----
// Rev 1.0
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_SUMA  = 4'd0,
    OP_RESTA = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_MOD   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9
  } op_e;

  localparam logic [3:0] SELECCION_MAX = 4'd9;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    EJECUTAR  = 2'd1,
    RESPONDER = 2'd2
  } estado_e;

  // Illegal opcode, or division/modulo whose divisor is zero.
  function automatic logic comando_invalido(input logic [3:0] sel, input logic b_cero);
    logic es_div;
    es_div = (sel == OP_DIV) || (sel == OP_MOD);
    return (sel > SELECCION_MAX) || (es_div && b_cero);
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_alu.sv
// ---- controlador_alu: command/response sequencer around an external combinational ALU ----
// Rev 1.0
`default_nettype none

module controlador_alu
  import alu_pkg::*;
#(
  parameter int ancho      = 3,
  parameter int ESPERA     = 1,
  parameter int ANCHO_CONT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valido,
  output logic                  cmd_listo,
  input  logic [ancho:0]        cmd_operandoA,
  input  logic [ancho:0]        cmd_operandoB,
  input  logic [3:0]            cmd_seleccion,
  input  logic                  cmd_acumular,
  output logic [ancho:0]        operandoA,
  output logic [ancho:0]        operandoB,
  output logic [3:0]            seleccion,
  input  logic [ancho:0]        resultado,
  input  logic [3:0]            banderas,
  output logic                  rsp_valido,
  input  logic                  rsp_listo,
  output logic [ancho:0]        rsp_resultado,
  output logic [3:0]            rsp_banderas,
  output logic                  rsp_error,
  output logic [ANCHO_CONT-1:0] ops_completadas
);

  localparam logic [3:0] c_ULTIMO = 4'(ESPERA - 1);

  estado_e               r_estado;
  estado_e               w_estado_sig;
  logic [3:0]            r_espera;
  logic [ancho:0]        r_opA;
  logic [ancho:0]        r_opB;
  logic [3:0]            r_sel;
  logic [ancho:0]        r_acum;
  logic [ancho:0]        r_res;
  logic [3:0]            r_flg;
  logic                  r_err;
  logic [ANCHO_CONT-1:0] r_ops;

  logic w_cmd_error;
  logic w_acepta;
  logic w_fin_espera;
  logic w_rsp_hs;
  logic w_cmd_listo;
  logic w_rsp_valido;

  assign w_cmd_error  = comando_invalido(cmd_seleccion, cmd_operandoB == '0);
  assign w_acepta     = (r_estado == INACTIVO) && cmd_valido;
  assign w_fin_espera = (r_estado == EJECUTAR) && (r_espera == c_ULTIMO);
  assign w_rsp_hs     = (r_estado == RESPONDER) && rsp_listo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= INACTIVO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_cmd_listo  = 1'b0;
    w_rsp_valido = 1'b0;
    case (r_estado)
      INACTIVO: begin
        w_cmd_listo = 1'b1;
        if (cmd_valido) begin
          w_estado_sig = w_cmd_error ? RESPONDER : EJECUTAR;
        end
      end
      EJECUTAR: begin
        if (w_fin_espera) begin
          w_estado_sig = RESPONDER;
        end
      end
      RESPONDER: begin
        w_rsp_valido = 1'b1;
        if (rsp_listo) begin
          w_estado_sig = INACTIVO;
        end
      end
      default: w_estado_sig = INACTIVO;
    endcase
  end

  // Rejected commands never touch the ALU ports; only the response registers load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_espera <= 4'd0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_sel    <= 4'd0;
      r_res    <= '0;
      r_flg    <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_acepta) begin
        if (w_cmd_error) begin
          r_res <= '0;
          r_flg <= 4'd0;
          r_err <= 1'b1;
        end else begin
          r_opA    <= cmd_acumular ? r_acum : cmd_operandoA;
          r_opB    <= cmd_operandoB;
          r_sel    <= cmd_seleccion;
          r_espera <= 4'd0;
        end
      end
      if (r_estado == EJECUTAR) begin
        r_espera <= r_espera + 4'd1;
        if (w_fin_espera) begin
          r_res <= resultado;
          r_flg <= banderas;
          r_err <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acum <= '0;
      r_ops  <= '0;
    end else if (w_rsp_hs && !r_err) begin
      r_acum <= r_res;
      r_ops  <= r_ops + ANCHO_CONT'(1);
    end
  end

  assign cmd_listo       = w_cmd_listo;
  assign rsp_valido      = w_rsp_valido;
  assign operandoA       = r_opA;
  assign operandoB       = r_opB;
  assign seleccion       = r_sel;
  assign rsp_resultado   = r_res;
  assign rsp_banderas    = r_flg;
  assign rsp_error       = r_err;
  assign ops_completadas = r_ops;

endmodule

`default_nettype wire

// File: tb/tb_controlador_alu.sv
// ---- tb_controlador_alu: vector table plus scoreboard for controlador_alu with a reference ALU ----
// Rev 1.0
`default_nettype none

module tb_controlador_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valido = 1'b0;
  logic       cmd_listo;
  logic [3:0] cmd_operandoA = 4'd0;
  logic [3:0] cmd_operandoB = 4'd0;
  logic [3:0] cmd_seleccion = 4'd0;
  logic       cmd_acumular = 1'b0;
  logic [3:0] operandoA;
  logic [3:0] operandoB;
  logic [3:0] seleccion;
  logic [3:0] resultado;
  logic [3:0] banderas;
  logic       rsp_valido;
  logic       rsp_listo = 1'b0;
  logic [3:0] rsp_resultado;
  logic [3:0] rsp_banderas;
  logic       rsp_error;
  logic [7:0] ops_completadas;

  always #5 clk = ~clk;

  controlador_alu #(.ancho(3), .ESPERA(1), .ANCHO_CONT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valido(cmd_valido), .cmd_listo(cmd_listo),
    .cmd_operandoA(cmd_operandoA), .cmd_operandoB(cmd_operandoB),
    .cmd_seleccion(cmd_seleccion), .cmd_acumular(cmd_acumular),
    .operandoA(operandoA), .operandoB(operandoB), .seleccion(seleccion),
    .resultado(resultado), .banderas(banderas),
    .rsp_valido(rsp_valido), .rsp_listo(rsp_listo),
    .rsp_resultado(rsp_resultado), .rsp_banderas(rsp_banderas),
    .rsp_error(rsp_error), .ops_completadas(ops_completadas)
  );

  // Stand-in for the external ALU; flags are {zero, msb, 1, 0}.
  always_comb begin
    case (seleccion)
      4'd0: resultado = operandoA + operandoB;
      4'd1: resultado = operandoA - operandoB;
      4'd2: resultado = operandoA * operandoB;
      4'd3: resultado = (operandoB != 4'd0) ? operandoA / operandoB : 4'd0;
      4'd4: resultado = (operandoB != 4'd0) ? operandoA % operandoB : 4'd0;
      4'd5: resultado = operandoA & operandoB;
      4'd6: resultado = operandoA | operandoB;
      4'd7: resultado = operandoA ^ operandoB;
      4'd8: resultado = operandoA << operandoB;
      4'd9: resultado = operandoA >> operandoB;
      default: resultado = 4'd0;
    endcase
    banderas = {resultado == 4'd0, resultado[3], 2'b10};
  end

  typedef struct {
    logic [3:0] a, b, sel;
    logic       acc, early;
    logic [3:0] res, flg;
    logic       err;
    logic [3:0] opa;
  } vec_t;

  typedef struct {
    logic [3:0] res, flg;
    logic       err;
  } rsp_t;

  rsp_t q[$];
  vec_t tab[17];
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_ops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    rsp_t       e;
    logic [3:0] pa, pb, ps;
    int         n;
    n = 0;
    while (!cmd_listo && n < 50) begin @(negedge clk); n++; end
    if (!cmd_listo) chk("listo_timeout", 32'(cmd_listo), 32'd1);
    pa = operandoA; pb = operandoB; ps = seleccion;
    q.push_back('{v.res, v.flg, v.err});
    rsp_listo     = v.early;
    cmd_operandoA = v.a;
    cmd_operandoB = v.b;
    cmd_seleccion = v.sel;
    cmd_acumular  = v.acc;
    cmd_valido    = 1'b1;
    @(posedge clk);
    #1 cmd_valido = 1'b0;
    @(negedge clk);
    if (v.err) begin
      chk("err_latency", 32'(rsp_valido), 32'd1);
      chk("hold_A", 32'(operandoA), 32'(pa));
      chk("hold_B", 32'(operandoB), 32'(pb));
      chk("hold_sel", 32'(seleccion), 32'(ps));
    end else begin
      chk("valido_early", 32'(rsp_valido), 32'd0);
      chk("listo_exec", 32'(cmd_listo), 32'd0);
      chk("alu_A", 32'(operandoA), 32'(v.opa));
      chk("alu_B", 32'(operandoB), 32'(v.b));
      chk("alu_sel", 32'(seleccion), 32'(v.sel));
      @(negedge clk);
      chk("ok_latency", 32'(rsp_valido), 32'd1);
    end
    n = 0;
    while (!rsp_valido && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valido) chk("valido_timeout", 32'(rsp_valido), 32'd1);
    e = q.pop_front();
    chk("rsp_res", 32'(rsp_resultado), 32'(e.res));
    chk("rsp_flg", 32'(rsp_banderas), 32'(e.flg));
    chk("rsp_err", 32'(rsp_error), 32'(e.err));
    rsp_listo = 1'b1;
    @(posedge clk);
    #1 rsp_listo = 1'b0;
    if (!e.err) exp_ops++;
    chk("listo_after", 32'(cmd_listo), 32'd1);
    chk("valido_after", 32'(rsp_valido), 32'd0);
    chk("ops", 32'(ops_completadas), 32'(exp_ops[7:0]));
  endtask

  initial begin
    //            a      b      sel    acc   early res    flg       err   opa
    tab[0]  = '{4'd5,  4'd3,  4'd0,  1'b0, 1'b0, 4'd8,  4'b0110, 1'b0, 4'd5};
    tab[1]  = '{4'd7,  4'd0,  4'd3,  1'b0, 1'b0, 4'd0,  4'b0000, 1'b1, 4'd0};
    tab[2]  = '{4'd1,  4'd1,  4'd12, 1'b0, 1'b1, 4'd0,  4'b0000, 1'b1, 4'd0};
    tab[3]  = '{4'd6,  4'd2,  4'd0,  1'b0, 1'b0, 4'd8,  4'b0110, 1'b0, 4'd6};
    tab[4]  = '{4'd0,  4'd3,  4'd1,  1'b1, 1'b0, 4'd5,  4'b0010, 1'b0, 4'd8};
    tab[5]  = '{4'd3,  4'd4,  4'd2,  1'b0, 1'b0, 4'd12, 4'b0110, 1'b0, 4'd3};
    tab[6]  = '{4'd9,  4'd4,  4'd4,  1'b0, 1'b0, 4'd1,  4'b0010, 1'b0, 4'd9};
    tab[7]  = '{4'd12, 4'd10, 4'd5,  1'b0, 1'b0, 4'd8,  4'b0110, 1'b0, 4'd12};
    tab[8]  = '{4'd12, 4'd3,  4'd6,  1'b0, 1'b1, 4'd15, 4'b0110, 1'b0, 4'd12};
    tab[9]  = '{4'd5,  4'd5,  4'd7,  1'b0, 1'b0, 4'd0,  4'b1010, 1'b0, 4'd5};
    tab[10] = '{4'd3,  4'd2,  4'd8,  1'b0, 1'b0, 4'd12, 4'b0110, 1'b0, 4'd3};
    tab[11] = '{4'd12, 4'd3,  4'd9,  1'b0, 1'b0, 4'd1,  4'b0010, 1'b0, 4'd12};
    tab[12] = '{4'd6,  4'd0,  4'd4,  1'b1, 1'b0, 4'd0,  4'b0000, 1'b1, 4'd0};
    tab[13] = '{4'd15, 4'd1,  4'd0,  1'b0, 1'b0, 4'd0,  4'b1010, 1'b0, 4'd15};
    tab[14] = '{4'd9,  4'd4,  4'd3,  1'b1, 1'b0, 4'd0,  4'b1010, 1'b0, 4'd0};
    tab[15] = '{4'd8,  4'd1,  4'd9,  1'b0, 1'b0, 4'd4,  4'b0010, 1'b0, 4'd8};
    tab[16] = '{4'd8,  4'd1,  4'd10, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b1, 4'd0};

    repeat (3) @(negedge clk);
    chk("rst_listo", 32'(cmd_listo), 32'd1);
    chk("rst_valido", 32'(rsp_valido), 32'd0);
    chk("rst_A", 32'(operandoA), 32'd0);
    chk("rst_sel", 32'(seleccion), 32'd0);
    chk("rst_ops", 32'(ops_completadas), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) do_op(tab[i]);

    // Backpressure: response held five cycles while a stray command is ignored.
    while (!cmd_listo) @(negedge clk);
    cmd_operandoA = 4'd2; cmd_operandoB = 4'd1; cmd_seleccion = 4'd0; cmd_acumular = 1'b0;
    cmd_valido = 1'b1;
    @(posedge clk);
    #1 cmd_valido = 1'b0;
    for (int n = 0; n < 50 && !rsp_valido; n++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_operandoA = 4'd9; cmd_operandoB = 4'd9; cmd_seleccion = 4'd2; cmd_valido = 1'b1;
      end
      if (c == 3) cmd_valido = 1'b0;
      chk("bp_valido", 32'(rsp_valido), 32'd1);
      chk("bp_listo", 32'(cmd_listo), 32'd0);
      chk("bp_res", 32'(rsp_resultado), 32'd3);
      chk("bp_flg", 32'(rsp_banderas), 32'b0010);
    end
    rsp_listo = 1'b1;
    @(posedge clk);
    #1 rsp_listo = 1'b0;
    exp_ops++;
    chk("bp_listo_after", 32'(cmd_listo), 32'd1);
    chk("bp_ops", 32'(ops_completadas), 32'(exp_ops[7:0]));
    chk("bp_A_kept", 32'(operandoA), 32'd2);
    chk("bp_sel_kept", 32'(seleccion), 32'd0);
    @(negedge clk);
    chk("bp_no_queue", 32'(rsp_valido), 32'd0);

    // Asynchronous reset while executing.
    cmd_operandoA = 4'd4; cmd_operandoB = 4'd4; cmd_seleccion = 4'd0; cmd_valido = 1'b1;
    @(posedge clk);
    #1 cmd_valido = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_listo", 32'(cmd_listo), 32'd1);
    chk("ar_valido", 32'(rsp_valido), 32'd0);
    chk("ar_A", 32'(operandoA), 32'd0);
    chk("ar_B", 32'(operandoB), 32'd0);
    chk("ar_res", 32'(rsp_resultado), 32'd0);
    chk("ar_ops", 32'(ops_completadas), 32'd0);
    exp_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op('{4'd7, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
